// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the digit-recognition layer sequencer.
package cnn_seq_pkg;

    localparam int DEF_N_STAGES = 5;

    localparam int STG_CONV1 = 0;
    localparam int STG_POOL1 = 1;
    localparam int STG_CONV2 = 2;
    localparam int STG_POOL2 = 3;
    localparam int STG_FC    = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4,
        S_ERROR  = 3'd5
    } seq_state_t;

    // Bits needed to hold 0..terminal, never less than one.
    function automatic int timer_width(input int terminal);
        return (terminal > 0) ? $clog2(terminal + 1) : 1;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Up-counter that restarts from zero on load and saturates at TERMINAL.
module seq_timer
    import cnn_seq_pkg::*;
#(
    parameter int TERMINAL = 1,
    parameter int WIDTH    = timer_width(TERMINAL)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] count;

    assign tc = (count == WIDTH'(TERMINAL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= '0;
        else if (en && !tc)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/layer_sequencer.sv
// Runs the per-layer counters in order: clear, enable until done, drain, next stage.
module layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int N_STAGES       = DEF_N_STAGES,
    parameter int DRAIN_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [N_STAGES-1:0] stage_done,
    output logic [N_STAGES-1:0] stage_en,
    output logic [N_STAGES-1:0] stage_clr,
    output logic [2:0]          cur_stage,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int IW         = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    seq_state_t    state, nxt;
    logic [IW-1:0] k, k_nxt;
    logic          first_run, hit, wd_tc, drain_tc, start_ok;

    // The done flag is still settling from the clear in the first RUN cycle.
    assign hit = stage_done[k] && !first_run;

    seq_timer #(.TERMINAL(TIMEOUT_CYCLES - 1)) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .load  (state != S_RUN),
        .en    (state == S_RUN),
        .tc    (wd_tc)
    );

    seq_timer #(.TERMINAL(DRAIN_LAST)) u_drain (
        .clk   (clk),
        .reset (reset),
        .load  (state != S_DRAIN),
        .en    (state == S_DRAIN),
        .tc    (drain_tc)
    );

    always_comb begin
        nxt   = state;
        k_nxt = k;
        unique case (state)
            S_IDLE: if (start && !abort) begin
                nxt   = S_CLR;
                k_nxt = '0;
            end
            S_ERROR: if (start) begin
                nxt   = S_CLR;
                k_nxt = '0;
            end
            S_CLR:   nxt = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)      nxt = S_IDLE;
                else if (hit)   nxt = S_DRAIN;
                else if (wd_tc) nxt = S_ERROR;
            end
            S_DRAIN: begin
                if (abort)
                    nxt = S_IDLE;
                else if (drain_tc) begin
                    if (k == IW'(N_STAGES - 1)) begin
                        nxt = S_FINISH;
                    end else begin
                        nxt   = S_CLR;
                        k_nxt = k + IW'(1);
                    end
                end
            end
            S_FINISH: nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    assign start_ok = (state == S_IDLE || state == S_ERROR) && (nxt == S_CLR);

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            first_run <= 1'b0;
            stage_en  <= '0;
            stage_clr <= '0;
            cur_stage <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= nxt;
            k         <= k_nxt;
            first_run <= (state == S_CLR);
            stage_clr <= (nxt == S_CLR) ? (N_STAGES'(1) << k_nxt) : '0;
            stage_en  <= (nxt == S_RUN) ? (N_STAGES'(1) << k_nxt) : '0;
            busy      <= (nxt == S_CLR) || (nxt == S_RUN) || (nxt == S_DRAIN);
            cur_stage <= (nxt == S_CLR || nxt == S_RUN || nxt == S_DRAIN || nxt == S_ERROR)
                         ? 3'(k_nxt) : 3'd0;
            if (start_ok)
                done <= 1'b0;
            else if (state == S_FINISH)
                done <= 1'b1;
            if (start_ok)
                error <= 1'b0;
            else if (state == S_RUN && nxt == S_ERROR)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scenario bench: stage counters modelled as latency counters, outputs checked
// every cycle against a timeline computed from per-stage run lengths.
module tb_layer_sequencer;

    localparam int NS      = 5;
    localparam int DRAIN   = 2;
    localparam int TIMEOUT = 4096;
    localparam int NEVER   = 1000000;

    logic          clk, reset, start, abort;
    logic [NS-1:0] stage_done, stage_en, stage_clr;
    logic [2:0]    cur_stage;
    logic          busy, done, error;

    int checks   = 0;
    int failures = 0;

    int lat[NS];       // enabled cycles until a counter raises done
    int R[NS];         // resulting RUN length seen by the sequencer
    int cnt[NS];
    int to_stage = -1; // stage that never finishes, or -1
    int abort_t  = -1; // cycle in which abort is driven, or -1
    bit force_done = 0;

    layer_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .stage_done (stage_done),
        .stage_en   (stage_en),
        .stage_clr  (stage_clr),
        .cur_stage  (cur_stage),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage counter environment: cleared by clr or reset, counts enabled cycles.
    always @(posedge clk or posedge reset) begin
        for (int j = 0; j < NS; j++) begin
            if (reset || stage_clr[j]) cnt[j] <= 0;
            else if (stage_en[j])      cnt[j] <= cnt[j] + 1;
        end
    end

    always @* begin
        for (int j = 0; j < NS; j++)
            stage_done[j] = force_done || (lat[j] < NEVER && cnt[j] >= lat[j] - 1);
    end

    function automatic logic [15:0] observe();
        return {stage_en, stage_clr, cur_stage, busy, done, error};
    endfunction

    // Expected {en, clr, cur, busy, done, error} in cycle t after the start edge.
    function automatic logic [15:0] model(input int t);
        int b;
        logic [4:0] oh;
        b = 0;
        if (abort_t >= 0 && t > abort_t) return 16'h0000;
        for (int k = 0; k < NS; k++) begin
            oh = 5'b00001 << k;
            if (t == b) return {5'b0, oh, 3'(k), 1'b1, 2'b00};
            if (k == to_stage) begin
                if (t <= b + TIMEOUT) return {oh, 5'b0, 3'(k), 1'b1, 2'b00};
                return {10'b0, 3'(k), 1'b0, 2'b01};
            end
            if (t <= b + R[k])         return {oh, 5'b0, 3'(k), 1'b1, 2'b00};
            if (t <= b + R[k] + DRAIN) return {10'b0, 3'(k), 1'b1, 2'b00};
            b += 1 + R[k] + DRAIN;
        end
        if (t == b) return 16'h0000;
        return 16'h0002;
    endfunction

    function automatic int total();
        int s;
        s = 0;
        for (int k = 0; k < NS; k++) s += 1 + R[k] + DRAIN;
        return s;
    endfunction

    function automatic int stage_base(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += 1 + R[j] + DRAIN;
        return s;
    endfunction

    task automatic set_lat(input int fixed);
        for (int k = 0; k < NS; k++) begin
            lat[k] = (fixed > 0) ? fixed : int'($urandom_range(1, 12));
            R[k]   = (lat[k] < 2) ? 2 : lat[k];
        end
    endtask

    // Start accepted at the posedge that opens cycle 0.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #3;
        checks++;
        if (observe() !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0000", observe());
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        checks++;
        if (observe() !== 16'h0) begin
            failures++;
            $display("FAIL after_reset got=%h exp=0000", observe());
        end
    endtask

    task automatic test_nominal();
        int done_t;
        logic [15:0] o, e;
        done_t = -1;
        set_lat(20);
        pulse_start();
        for (int t = 0; t <= total() + 3; t++) begin
            @(negedge clk);
            o = observe(); e = model(t);
            if (done && done_t < 0) done_t = t;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL nominal_trace t=%0d got=%h exp=%h", t, o, e);
                break;
            end
        end
        checks++;
        if (done_t != 5 * (1 + 20 + 2) + 1) begin
            failures++;
            $display("FAIL nominal_total got=%0d exp=%0d", done_t, 5 * 23 + 1);
        end
    endtask

    task automatic test_random(input int iter);
        logic [15:0] o, e;
        set_lat(0);
        pulse_start();
        for (int t = 0; t <= total() + 2; t++) begin
            @(negedge clk);
            o = observe(); e = model(t);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random_trace%0d t=%0d got=%h exp=%h", iter, t, o, e);
                break;
            end
        end
    endtask

    task automatic test_stale_done();
        logic [15:0] o, e;
        set_lat(NEVER);
        for (int k = 0; k < NS; k++) R[k] = 2;
        force_done = 1'b1;
        pulse_start();
        for (int t = 0; t <= total() + 2; t++) begin
            @(negedge clk);
            o = observe(); e = model(t);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stale_trace t=%0d got=%h exp=%h", t, o, e);
                break;
            end
        end
        force_done = 1'b0;
    endtask

    task automatic test_timeout();
        int en_t, err_t;
        logic [15:0] o, e;
        en_t = -1; err_t = -1;
        set_lat(0);
        lat[2] = NEVER;
        to_stage = 2;
        pulse_start();
        for (int t = 0; t <= stage_base(2) + TIMEOUT + 4; t++) begin
            @(negedge clk);
            o = observe(); e = model(t);
            if (stage_en[2] && en_t < 0) en_t = t;
            if (error && err_t < 0) err_t = t;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL timeout_trace t=%0d got=%h exp=%h", t, o, e);
                break;
            end
        end
        checks++;
        if (err_t - en_t != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=%0d", err_t - en_t, TIMEOUT);
        end
        // abort has no effect in ERROR
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        @(negedge clk);
        checks++;
        if (observe() !== {10'b0, 3'd2, 1'b0, 2'b01}) begin
            failures++;
            $display("FAIL error_hold got=%h exp=%h", observe(), {10'b0, 3'd2, 1'b0, 2'b01});
        end
        to_stage = -1;
        test_random(99);
    endtask

    task automatic test_abort();
        logic [15:0] o, e;
        set_lat(0);
        abort_t = stage_base(3) + R[3];
        pulse_start();
        for (int t = 0; t <= abort_t + 6; t++) begin
            @(negedge clk);
            o = observe(); e = model(t);
            abort = (t == abort_t);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL abort_trace t=%0d got=%h exp=%h", t, o, e);
                break;
            end
        end
        abort = 1'b0;
        abort_t = -1;
    endtask

    task automatic test_start_busy();
        logic [15:0] o, e;
        set_lat(0);
        pulse_start();
        for (int t = 0; t <= total() + 2; t++) begin
            @(negedge clk);
            o = observe(); e = model(t);
            start = (t == stage_base(1) + 2);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL busy_start_trace t=%0d got=%h exp=%h", t, o, e);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_idle_start_abort();
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (observe() !== 16'h0002) begin
                failures++;
                $display("FAIL idle_start_abort t=%0d got=%h exp=0002", t, observe());
            end
        end
    endtask

    task automatic test_async_reset();
        int tr;
        logic [15:0] o, e;
        set_lat(0);
        tr = stage_base(1) + R[1] + 1;
        pulse_start();
        for (int t = 0; t <= tr; t++) @(negedge clk);
        o = observe(); e = model(tr);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL pre_reset_drain got=%h exp=%h", o, e);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (observe() !== 16'h0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0000", observe());
        end
        @(negedge clk) reset = 1'b0;
        test_random(100);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        for (int k = 0; k < NS; k++) lat[k] = NEVER;
        test_reset();
        test_nominal();
        for (int i = 0; i < 3; i++) test_random(i);
        test_stale_done();
        test_timeout();
        test_abort();
        test_start_busy();
        test_idle_start_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
